// File: rtl/dsp48a1_mac_sequencer_if.sv
// Stream, slice and result signals between host logic, the MAC sequencer and one DSP48A1 slice.
// The master side is the host/slice environment; the slave side is the sequencer.
interface dsp48a1_mac_sequencer_if #(
  parameter int WIDTH_AB = 18,
  parameter int CNT_W    = 10
);
  logic                       start;
  logic [CNT_W-1:0]           len;
  logic                       busy;
  logic                       op_valid;
  logic                       op_ready;
  logic signed [WIDTH_AB-1:0] a_in;
  logic signed [WIDTH_AB-1:0] b_in;
  logic signed [WIDTH_AB-1:0] dsp_a;
  logic signed [WIDTH_AB-1:0] dsp_b;
  logic [7:0]                 dsp_opmode;
  logic                       dsp_ce_ab;
  logic                       dsp_ce_p;
  logic [47:0]                dsp_p;
  logic                       res_valid;
  logic                       res_ready;
  logic [47:0]                res_data;

  modport master (
    output start, len, op_valid, a_in, b_in, dsp_p, res_ready,
    input  busy, op_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce_ab, dsp_ce_p, res_valid, res_data
  );

  modport slave (
    input  start, len, op_valid, a_in, b_in, dsp_p, res_ready,
    output busy, op_ready, dsp_a, dsp_b, dsp_opmode, dsp_ce_ab, dsp_ce_p, res_valid, res_data
  );
endinterface

// File: rtl/dsp48a1_mac_sequencer.sv
// Job controller for a DSP48A1 MAC: result valid PIPE_LAT edges after the last accept;
// operands stall via op_ready outside FEED, result holds until res_ready.
module dsp48a1_mac_sequencer #(
  parameter int         WIDTH_AB  = 18,
  parameter int         CNT_W     = 10,
  parameter int         PIPE_LAT  = 3,
  parameter logic [7:0] OPM_FIRST = 8'h01,
  parameter logic [7:0] OPM_ACC   = 8'h09
) (
  input logic                   clk,
  input logic                   rst,
  dsp48a1_mac_sequencer_if.slave bus
);
  localparam int TAG_D = PIPE_LAT - 1;

  typedef enum logic [1:0] {IDLE, FEED, DRAIN, RESULT} state_t;

  typedef struct packed {
    logic vld;
    logic first;
    logic last;
  } tag_t;

  state_t            state_q;
  tag_t [TAG_D-1:0]  tag_q;
  logic [CNT_W-1:0]  rem_q;
  logic              first_q;
  logic              p_done_q;
  logic              busy_q;
  logic              op_ready_q;
  logic              res_valid_q;
  logic [47:0]       res_data_q;

  logic accept;
  tag_t tag_d;
  tag_t tag_fin;

  assign accept  = bus.op_valid & op_ready_q;
  assign tag_fin = tag_q[TAG_D-1];

  always_comb begin
    tag_d       = '0;
    tag_d.vld   = accept;
    tag_d.first = accept & first_q;
    tag_d.last  = accept & (rem_q == CNT_W'(1));
  end

  // p_done_q trails the final tag stage by one edge so res_data samples P after its capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      tag_q       <= '0;
      rem_q       <= '0;
      first_q     <= 1'b0;
      p_done_q    <= 1'b0;
      busy_q      <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      tag_q[0] <= tag_d;
      for (int i = 1; i < TAG_D; i++) tag_q[i] <= tag_q[i-1];
      p_done_q <= tag_fin.vld & tag_fin.last;

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              rem_q      <= bus.len;
              first_q    <= 1'b1;
              op_ready_q <= 1'b1;
              state_q    <= FEED;
            end else begin
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
              state_q     <= RESULT;
            end
          end
        end
        FEED: begin
          if (accept) begin
            rem_q   <= rem_q - CNT_W'(1);
            first_q <= 1'b0;
            if (rem_q == CNT_W'(1)) begin
              op_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (p_done_q) begin
            res_data_q  <= bus.dsp_p;
            res_valid_q <= 1'b1;
            state_q     <= RESULT;
          end
        end
        RESULT: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.dsp_a      = bus.a_in[WIDTH_AB-1:0];
  assign bus.dsp_b      = bus.b_in[WIDTH_AB-1:0];
  assign bus.dsp_ce_ab  = 1'b1;
  assign bus.dsp_ce_p   = tag_fin.vld;
  // Idle stages present OPM_FIRST so the output matches its reset value; P is not enabled then.
  assign bus.dsp_opmode = (tag_fin.vld & ~tag_fin.first) ? OPM_ACC : OPM_FIRST;
  assign bus.busy       = busy_q;
  assign bus.op_ready   = op_ready_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
endmodule

// File: tb/tb_dsp48a1_mac_sequencer.sv
// Bench for dsp48a1_mac_sequencer: behavioural DSP48A1 slice plus dot-product reference model.
module tb_dsp48a1_mac_sequencer;
  localparam int         PIPE_LAT  = 3;
  localparam logic [7:0] OPM_FIRST = 8'h01;
  localparam logic [7:0] OPM_ACC   = 8'h09;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dsp48a1_mac_sequencer_if bus ();

  dsp48a1_mac_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Slice model: AREG/BREG, MREG, PREG with X/Z decoded from OPMODE; not reset, so P can go stale.
  logic signed [17:0] a_r = '0;
  logic signed [17:0] b_r = '0;
  logic signed [35:0] m_r = '0;
  logic [47:0]        p_r = 48'h0000_5A5A_C3C3;
  logic [47:0]        x_mux, z_mux;
  always_comb begin
    x_mux = (bus.dsp_opmode[1:0] == 2'b01) ? {{12{m_r[35]}}, m_r} : 48'd0;
    z_mux = (bus.dsp_opmode[3:2] == 2'b10) ? p_r : 48'd0;
  end
  always @(posedge clk) begin
    if (bus.dsp_ce_ab) begin
      a_r <= bus.dsp_a;
      b_r <= bus.dsp_b;
      m_r <= a_r * b_r;
    end
    if (bus.dsp_ce_p) p_r <= z_mux + x_mux;
  end
  assign bus.dsp_p = p_r;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Passive monitor, sampled on the falling edge.
  int         cyc = 0;
  int         acc_edge = 0;
  int         pass_bad = 0;
  logic [7:0] cep_opm[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.op_valid && bus.op_ready) acc_edge = cyc + 1;
      if (bus.dsp_ce_p) cep_opm.push_back(bus.dsp_opmode);
      if (bus.dsp_a !== bus.a_in || bus.dsp_b !== bus.b_in || bus.dsp_ce_ab !== 1'b1) pass_bad++;
    end
  end

  int av[0:63];
  int bv[0:63];

  task automatic check_reset(input string pfx);
    check({pfx, "_busy"},      64'(bus.busy), 64'(0));
    check({pfx, "_op_ready"},  64'(bus.op_ready), 64'(0));
    check({pfx, "_ce_p"},      64'(bus.dsp_ce_p), 64'(0));
    check({pfx, "_opmode"},    64'(bus.dsp_opmode), 64'(OPM_FIRST));
    check({pfx, "_res_valid"}, 64'(bus.res_valid), 64'(0));
    check({pfx, "_res_data"},  64'(bus.res_data), 64'(0));
  endtask

  // Presents n pairs from av/bv; entered and left just after a rising edge.
  task automatic feed(input int n, input int gap_fixed, input int gap_rand);
    int tmo;
    for (int i = 0; i < n; i++) begin
      repeat (gap_fixed + int'($urandom_range(0, gap_rand))) begin
        bus.op_valid = 1'b0;
        bus.a_in     = 18'($urandom);
        bus.b_in     = 18'($urandom);
        @(posedge clk); #1;
      end
      bus.op_valid = 1'b1;
      bus.a_in     = 18'(av[i]);
      bus.b_in     = 18'(bv[i]);
      tmo = 0;
      @(negedge clk);
      while (!bus.op_ready && tmo < 50) begin
        @(negedge clk);
        tmo++;
      end
      check("op_ready_wait", 64'(tmo < 50), 64'(1));
      @(posedge clk); #1;
      bus.op_valid = 1'b0;
    end
  endtask

  task automatic run_job(input int len, input int gap_fixed, input int gap_rand,
                         input int hold, input bit pulse_start);
    logic [47:0] exp_sum;
    int          base_cep, tmo, start_edge, res_edge, bad_opm;
    exp_sum = '0;
    for (int i = 0; i < len; i++) exp_sum += 48'(longint'(av[i]) * longint'(bv[i]));

    tmo = 0;
    while (bus.busy && tmo < 100) begin
      @(negedge clk);
      tmo++;
    end
    check("idle_before_start", 64'(bus.busy), 64'(0));
    base_cep = cep_opm.size();

    @(posedge clk); #1;
    bus.start  = 1'b1;
    bus.len    = 10'(len);
    start_edge = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len   = 10'($urandom);
    feed(len, gap_fixed, gap_rand);

    tmo = 0;
    do begin
      @(negedge clk);
      tmo++;
    end while (!bus.res_valid && tmo < 200);
    res_edge = cyc;
    check("res_valid_rise", 64'(bus.res_valid), 64'(1));
    check("res_data", 64'(bus.res_data), 64'(exp_sum));
    check("ce_p_pulses", 64'(cep_opm.size() - base_cep), 64'(len));
    if (len > 0) begin
      bad_opm = 0;
      for (int i = base_cep + 1; i < cep_opm.size(); i++)
        if (cep_opm[i] != OPM_ACC) bad_opm++;
      check("opmode_first", 64'(cep_opm[base_cep]), 64'(OPM_FIRST));
      check("opmode_acc", 64'(bad_opm), 64'(0));
      check("latency", 64'(res_edge - acc_edge), 64'(PIPE_LAT));
    end else begin
      check("latency_len0", 64'(res_edge - start_edge), 64'(0));
    end

    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.start = pulse_start && (h == 1);
      bus.len   = 10'd3;
      @(negedge clk);
      check("hold_data", 64'(bus.res_data), 64'(exp_sum));
      check("hold_valid", 64'(bus.res_valid), 64'(1));
      check("hold_op_ready", 64'(bus.op_ready), 64'(0));
      check("hold_busy", 64'(bus.busy), 64'(1));
    end
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.res_ready = 1'b1;
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    check("post_res_valid", 64'(bus.res_valid), 64'(0));
    check("post_busy", 64'(bus.busy), 64'(0));
    check("no_ghost_pulses", 64'(cep_opm.size() - base_cep), 64'(len));
  endtask

  initial begin
    logic signed [17:0] r;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.op_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    rst = 1'b0;

    av[0:3] = '{1, 2, 3, 4};
    bv[0:3] = '{5, 6, 7, 8};
    run_job(4, 0, 0, 0, 1'b0);   // back-to-back operands
    run_job(4, 2, 0, 0, 1'b0);   // two-cycle gaps between pairs
    run_job(0, 0, 0, 0, 1'b0);   // empty job
    av[0] = -3; bv[0] = 5;
    run_job(1, 0, 0, 0, 1'b0);   // stale 70 must not be added
    av[0:3] = '{1, 2, 3, 4};
    bv[0:3] = '{5, 6, 7, 8};
    run_job(4, 0, 0, 5, 1'b1);   // result held under backpressure, start ignored

    // Reset in the middle of a job, then a fresh job.
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.len   = 10'd4;
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed(2, 0, 0);
    #2 rst = 1'b1;
    #1 check_reset("midjob_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    av[0:1] = '{3, 1};
    bv[0:1] = '{3, 1};
    run_job(2, 0, 0, 0, 1'b0);

    for (int j = 0; j < 8; j++) begin
      int n;
      n = int'($urandom_range(1, 16));
      for (int i = 0; i < n; i++) begin
        r = 18'($urandom); av[i] = int'(r);
        r = 18'($urandom); bv[i] = int'(r);
      end
      run_job(n, 0, 2, int'($urandom_range(0, 3)), 1'($urandom));
    end

    check("slice_passthrough", 64'(pass_bad), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule
